// File: rtl/main_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm_pkg
// Purpose : shared encodings for the multicycle RV32I control unit: FSM
//           states, ALU operation classes, opcode constants, ALUControl
//           codes and the mux-select codes driven onto the datapath.
// Contents: state_t, alu_class_t, opcode / ALU / select localparams,
//           immSrcFor() opcode-to-immediate-format helper,
//           branchFunct3Legal() branch funct3 filter.
// ---------------------------------------------------------------------------
package main_ctrl_fsm_pkg;

  // One state per instruction phase; S_RESET is the parked state while reset
  // is asserted and for the first cycle after release.
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALR_LNK = 4'd13,
    S_LUI      = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  // What kind of ALU operation the current state asks for; the ALU decoder
  // turns this plus the funct fields into the concrete ALUControl code.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_ALU    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_JALR   = 2'd3
  } alu_class_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUControl codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_ADDLC = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_BNE   = 4'b1010;
  localparam logic [3:0] ALU_BLT   = 4'b1011;
  localparam logic [3:0] ALU_SLTU  = 4'b1100;
  localparam logic [3:0] ALU_BGE   = 4'b1101;
  localparam logic [3:0] ALU_BLTU  = 4'b1110;
  localparam logic [3:0] ALU_BGEU  = 4'b1111;

  // ResultSrc codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALUSrcA / ALUSrcB codes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ImmSrc codes
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format for an opcode; unknown opcodes fall back to I-type,
  // which is harmless because they never reach a state that uses ImmExt.
  function automatic logic [2:0] immSrcFor(input logic [6:0] opcode);
    logic [2:0] imm;
    imm = IMM_I;
    case (opcode)
      OP_STORE:         imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

  // funct3 values 010 and 011 have no branch meaning in RV32I.
  function automatic logic branchFunct3Legal(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm_alu_decoder
// Purpose : combinational ALUControl generation for the control FSM.
// Ports   : aluClass_i   - operation class requested by the current state
//           opB5_i       - Instr[5], separates R-type (1) from I-type (0)
//           funct3_i     - Instr[14:12]
//           funct7b5_i   - Instr[30]
//           aluControl_o - 4-bit ALU operation code
// ---------------------------------------------------------------------------
module main_ctrl_fsm_alu_decoder
  import main_ctrl_fsm_pkg::*;
(
  input  alu_class_t aluClass_i,
  input  logic       opB5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] aluControl_o
);

  // R and I types share one funct3 map. Instr[30] is part of the immediate
  // for ADDI, so SUB needs both the R-type opcode bit and funct7b5; for the
  // right shifts Instr[30] selects SRA in both formats.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluClass_i)
      CLS_ALU: begin
        case (funct3_i)
          3'b000:  aluControl_o = (opB5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl_o = ALU_SLL;
          3'b010:  aluControl_o = ALU_SLT;
          3'b011:  aluControl_o = ALU_SLTU;
          3'b100:  aluControl_o = ALU_XOR;
          3'b101:  aluControl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  aluControl_o = ALU_OR;
          default: aluControl_o = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        // Each branch code makes the ALU raise Zero exactly when the branch
        // is taken, so the FSM only has to AND Branch with Zero.
        case (funct3_i)
          3'b000:  aluControl_o = ALU_SUB;
          3'b001:  aluControl_o = ALU_BNE;
          3'b100:  aluControl_o = ALU_BLT;
          3'b101:  aluControl_o = ALU_BGE;
          3'b110:  aluControl_o = ALU_BLTU;
          3'b111:  aluControl_o = ALU_BGEU;
          default: aluControl_o = ALU_ADD;
        endcase
      end
      CLS_JALR: aluControl_o = ALU_ADDLC;
      default:  aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm
// Purpose : multicycle RV32I control unit. Walks each instruction through
//           FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath strobes,
//           mux selects and ALUControl. Branches resolve on the ALU Zero flag.
// Ports   : clk, reset (async, active-high)
//           op, funct3, funct7b5   - instruction register fields
//           Zero                   - ALU Zero flag
//           PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - strobes/selects
//           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl - datapath codes
//           IllegalInstr           - one-cycle pulse for unsupported encodings
// ---------------------------------------------------------------------------
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       IllegalInstr
);

  state_t     state_q;
  state_t     state_d;
  logic       pcUpdate;
  logic       branch;
  alu_class_t aluClass;

  // State register. Reset is asynchronous so every strobe (all decoded from
  // state) drops in the same cycle reset rises and an in-flight write is
  // abandoned rather than completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DECODE is the only fan-out point; MEMADR picks load
  // versus store from Instr[5]. Branches with a meaningless funct3 are sent
  // to ILLEGAL instead of BRANCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = branchFunct3Legal(funct3) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_LNK;
      S_JALR_LNK: state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode. Everything defaults to 0 / ADD class. DECODE
  // precomputes OldPC+Imm into ALUOut, which is the branch or JAL target
  // consumed by the following state. JAL and JALR_LNK load the PC from
  // ALUOut while the ALU forms OldPC+4 for the link write in ALUWB.
  always_comb begin
    pcUpdate     = 1'b0;
    branch       = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    aluClass     = CLS_ADD;
    IllegalInstr = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pcUpdate  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        aluClass = CLS_ALU;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        aluClass = CLS_ALU;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
        aluClass  = CLS_BRANCH;
      end
      S_JAL, S_JALR_LNK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pcUpdate  = 1'b1;
      end
      S_JALR: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        aluClass = CLS_JALR;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
      end
      S_ILLEGAL: begin
        IllegalInstr = 1'b1;
      end
      default: begin
        pcUpdate = 1'b0;
      end
    endcase
  end

  // A taken branch reuses the PC enable; Zero is only qualified in BRANCH.
  assign PCWrite = pcUpdate | (branch & Zero);

  // Immediate format depends only on the opcode, independent of state.
  assign ImmSrc = immSrcFor(op);

  main_ctrl_fsm_alu_decoder uAluDecoder (
    .aluClass_i   (aluClass),
    .opB5_i       (op[5]),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .aluControl_o (ALUControl)
  );

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_ctrl_fsm
// Directed bench for the multicycle control FSM. For each instruction the
// expected per-cycle output vectors are queued when the inputs are applied,
// then popped and compared once per cycle at the falling clock edge.
// Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr}
// ---------------------------------------------------------------------------
module tb_main_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       IllegalInstr;

  typedef struct {
    string       tag;
    logic [18:0] vec;
  } exp_t;

  exp_t  sbQ[$];
  int    vectors;
  int    miscompares;
  string curInstr;
  logic [18:0] obsVec;

  main_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .IllegalInstr (IllegalInstr)
  );

  assign obsVec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [18:0] mk(input logic pcw, input logic adr,
                                     input logic mw, input logic ir,
                                     input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ill);
    return {pcw, adr, mw, ir, rw, rs, a, b, imm, alu, ill};
  endfunction

  task automatic pushExp(input string stateName, input logic [18:0] v);
    exp_t e;
    e.tag = {curInstr, "/", stateName};
    e.vec = v;
    sbQ.push_back(e);
  endtask

  // Expected vectors for each state, written out from the output table.
  task automatic pushReset(input logic [2:0] imm);
    pushExp("RESET", mk(0,0,0,0,0,2'b00,2'b00,2'b00,imm,4'b0000,0));
  endtask
  task automatic pushFetchDecode(input logic [2:0] imm);
    pushExp("FETCH",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,imm,4'b0000,0));
    pushExp("DECODE", mk(0,0,0,0,0,2'b00,2'b01,2'b01,imm,4'b0000,0));
  endtask
  task automatic pushAluWb(input logic [2:0] imm);
    pushExp("ALUWB",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,imm,4'b0000,0));
  endtask
  task automatic pushRType(input logic [3:0] alu);
    pushFetchDecode(3'b000);
    pushExp("EXECR",  mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,alu,0));
    pushAluWb(3'b000);
  endtask
  task automatic pushIType(input logic [3:0] alu);
    pushFetchDecode(3'b000);
    pushExp("EXECI",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,alu,0));
    pushAluWb(3'b000);
  endtask
  task automatic pushBranch(input logic taken, input logic [3:0] alu);
    pushFetchDecode(3'b010);
    pushExp("BRANCH", mk(taken,0,0,0,0,2'b00,2'b10,2'b00,3'b010,alu,0));
  endtask
  task automatic pushIllegal(input logic [2:0] imm);
    pushFetchDecode(imm);
    pushExp("ILLEGAL", mk(0,0,0,0,0,2'b00,2'b00,2'b00,imm,4'b0000,1));
  endtask

  // Inputs are applied just after a falling edge, so the next falling edge
  // samples the FETCH cycle of this instruction.
  task automatic applyStimulus(input string name, input logic [6:0] opV,
                               input logic [2:0] f3, input logic f7,
                               input logic z);
    curInstr = name;
    op       = opV;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
  endtask

  task automatic checkOutput(input bit waitEdge);
    exp_t e;
    if (waitEdge) @(negedge clk);
    vectors++;
    if (sbQ.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard-empty: observed=%b required=<queued vector>", obsVec);
    end else begin
      e = sbQ.pop_front();
      assert (obsVec === e.vec) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed=%b required=%b", e.tag, obsVec, e.vec);
      end
    end
  endtask

  task automatic drain();
    while (sbQ.size() > 0) checkOutput(1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    op          = 7'b0000000;
    funct3      = 3'b000;
    funct7b5    = 1'b0;
    Zero        = 1'b0;
    curInstr    = "init";

    // Reset held, then released mid-cycle: S_RESET outputs both times.
    pushReset(3'b000);
    checkOutput(1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    pushReset(3'b000);
    checkOutput(1'b1);

    // LW: F, D, MEMADR, MEMREAD, MEMWB (RegWrite only in the last cycle)
    applyStimulus("LW", 7'b0000011, 3'b010, 1'b0, 1'b0);
    pushFetchDecode(3'b000);
    pushExp("MEMADR",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0));
    pushExp("MEMREAD", mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
    pushExp("MEMWB",   mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'b0000,0));
    drain();

    // SW: F, D, MEMADR, MEMWRITE
    applyStimulus("SW", 7'b0100011, 3'b010, 1'b0, 1'b0);
    pushFetchDecode(3'b001);
    pushExp("MEMADR",   mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'b0000,0));
    pushExp("MEMWRITE", mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
    drain();

    // ALU decoding, R and I types
    applyStimulus("SUB",  7'b0110011, 3'b000, 1'b1, 1'b0); pushRType(4'b0001); drain();
    applyStimulus("ADDI", 7'b0010011, 3'b000, 1'b1, 1'b0); pushIType(4'b0000); drain();
    applyStimulus("SRA",  7'b0110011, 3'b101, 1'b1, 1'b0); pushRType(4'b1001); drain();
    applyStimulus("SRLI", 7'b0010011, 3'b101, 1'b0, 1'b0); pushIType(4'b1000); drain();
    applyStimulus("SRAI", 7'b0010011, 3'b101, 1'b1, 1'b0); pushIType(4'b1001); drain();
    applyStimulus("SLTU", 7'b0110011, 3'b011, 1'b0, 1'b0); pushRType(4'b1100); drain();
    applyStimulus("ANDI", 7'b0010011, 3'b111, 1'b0, 1'b0); pushIType(4'b0010); drain();
    applyStimulus("SLL",  7'b0110011, 3'b001, 1'b0, 1'b0); pushRType(4'b0111); drain();

    // Branches: PCWrite in BRANCH follows Zero
    applyStimulus("BNEz1",  7'b1100011, 3'b001, 1'b0, 1'b1); pushBranch(1'b1, 4'b1010); drain();
    applyStimulus("BNEz0",  7'b1100011, 3'b001, 1'b0, 1'b0); pushBranch(1'b0, 4'b1010); drain();
    applyStimulus("BEQ",    7'b1100011, 3'b000, 1'b0, 1'b1); pushBranch(1'b1, 4'b0001); drain();
    applyStimulus("BGEU",   7'b1100011, 3'b111, 1'b0, 1'b0); pushBranch(1'b0, 4'b1111); drain();
    applyStimulus("BLT",    7'b1100011, 3'b100, 1'b0, 1'b1); pushBranch(1'b1, 4'b1011); drain();

    // JAL: F, D, JAL, ALUWB
    applyStimulus("JAL", 7'b1101111, 3'b000, 1'b0, 1'b0);
    pushFetchDecode(3'b011);
    pushExp("JAL", mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,4'b0000,0));
    pushAluWb(3'b011);
    drain();

    // JALR: F, D, JALR, JALR_LNK, ALUWB
    applyStimulus("JALR", 7'b1100111, 3'b000, 1'b0, 1'b0);
    pushFetchDecode(3'b000);
    pushExp("JALR",     mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0100,0));
    pushExp("JALR_LNK", mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,4'b0000,0));
    pushAluWb(3'b000);
    drain();

    // LUI: F, D, LUI   AUIPC: F, D, ALUWB
    applyStimulus("LUI", 7'b0110111, 3'b000, 1'b0, 1'b0);
    pushFetchDecode(3'b100);
    pushExp("LUI", mk(0,0,0,0,1,2'b11,2'b00,2'b00,3'b100,4'b0000,0));
    drain();
    applyStimulus("AUIPC", 7'b0010111, 3'b000, 1'b0, 1'b0);
    pushFetchDecode(3'b100);
    pushAluWb(3'b100);
    drain();

    // Illegal opcode and illegal branch funct3, each followed by a FETCH
    applyStimulus("BADOP", 7'b1111111, 3'b000, 1'b0, 1'b0);
    pushIllegal(3'b000);
    drain();
    applyStimulus("BADBR", 7'b1100011, 3'b010, 1'b0, 1'b1);
    pushIllegal(3'b010);
    drain();
    applyStimulus("BADBR3", 7'b1100011, 3'b011, 1'b0, 1'b0);
    pushIllegal(3'b010);
    pushFetchDecode(3'b010);
    drain();
    // That second decode dispatches to ILLEGAL again, then returns to FETCH.
    pushExp("ILLEGAL2", mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b010,4'b0000,1));
    drain();

    // Reset asserted during MEMWRITE: strobes drop immediately
    applyStimulus("SWRST", 7'b0100011, 3'b010, 1'b0, 1'b0);
    pushFetchDecode(3'b001);
    pushExp("MEMADR",   mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'b0000,0));
    pushExp("MEMWRITE", mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
    drain();
    #1 reset = 1'b1;
    #1;
    pushReset(3'b001);
    checkOutput(1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    pushReset(3'b001);
    checkOutput(1'b1);
    applyStimulus("ADDIpost", 7'b0010011, 3'b000, 1'b0, 1'b0);
    pushIType(4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
